icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache: the responder end of the datapath's instruction-fetch request (imemREN/imemaddr answered by ihit/imemload).
- Serves hits combinationally.
- On a miss, fills one 2-word block from the memory side (iREN/iaddr/iwait/iload) through a small FSM.
- Sits between the pipelined datapath fetch stage and the memory controller/arbiter.

Parameters:
- SETS, 16, number of cache frames; power of two, ≥2. IDX_W = log2(SETS).
- PC_INIT, 0, unused by logic; documents the first expected fetch address for the bench.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- halt  in  1  datapath halted; no new fills start while high.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  requested instruction word.
- iREN  out  1  memory-side read request.
- iaddr  out  32  memory-side word address, word aligned.
- iwait  in  1  memory busy; iload is valid in the cycle iwait=0 while iREN=1.
- iload  in  32  memory-side read data.

Behaviour:
- Address split:
  - [1:0] byte offset (ignored).
  - [2] word-in-block.
  - [IDX_W+2:3] index.
  - [31:IDX_W+3] tag (25 bits at SETS=16).
- Storage per frame: valid bit, tag, data[2] of 32 bits each.
- Reset (RST=1 at posedge): all valid=0, state=IDLE, fill latches=0. Outputs during and after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- FSM states: IDLE, FILL0, FILL1.
- IDLE:
  - ihit = imemREN & valid[idx] & (tag[idx]==addr tag), combinational, zero-cycle latency.
  - imemload = data[idx][word] when ihit, else 0.
  - Miss (imemREN & !ihit & !halt): latch fill tag/index from imemaddr; next state FILL0.
- FILL0:
  - iREN=1, iaddr={ftag,fidx,1'b0,2'b00}.
  - iwait=1: hold.
  - iwait=0: data[fidx][0]<=iload; next state FILL1.
- FILL1:
  - iREN=1, iaddr={ftag,fidx,1'b1,2'b00}.
  - iwait=1: hold.
  - iwait=0: data[fidx][1]<=iload, tag[fidx]<=ftag, valid[fidx]<=1; next state IDLE.
- ihit=0 and imemload=0 in FILL0 and FILL1 regardless of imemaddr. The first hit comes in the cycle after the return to IDLE, so miss latency = 2 memory grants + 1 cycle.
- imemaddr changing mid-fill (e.g. a taken branch): the fill completes for the latched block and is never aborted. The new address is evaluated in IDLE.
- halt:
  - halt=1 in IDLE suppresses starting a fill; hits are still served.
  - halt=1 during a fill: the fill completes normally.
- imemREN=0 in IDLE: no state change, ihit=0.
- valid is set only after both words are written. A frame is never marked valid with partial data.
- Replacement: an unconditional overwrite of the indexed frame.
- RST asserted mid-fill: return to IDLE immediately, iREN=0 the next cycle, all valid cleared. The partial fill is discarded.
- No write path; instruction memory is read-only from this block.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count (32) and miss_count (32), reset to 0.
  - hit_count increments in each IDLE cycle where ihit=1.
  - miss_count increments on each IDLE->FILL0 transition.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then imemREN=1, imemaddr=0x0, memory returns 0x11111111 @0x0 and 0x22222222 @0x4 with iwait=0 each grant -> iaddr 0x0 then 0x4, FILL0/FILL1 one cycle each, ihit=1 with imemload=0x11111111 on the 3rd cycle; imemaddr=0x4 next cycle -> ihit=1, imemload=0x22222222 with no iREN.
- Conflict: fill 0x0, then fetch 0x80 (same index 0, different tag) -> miss, iaddr 0x80/0x84; refetch 0x0 -> miss again.
- iwait=1 for 3 cycles on each grant -> iREN held with stable iaddr, ihit=0 throughout, hit after fill completes.
- imemaddr switched from 0x10 to 0x40 during FILL0 -> block 0x10 completes (iaddr 0x10, 0x14) and frame 2 becomes valid; then 0x40 misses and fills.
- halt=1 with a miss pending in IDLE -> iREN stays 0; a previously filled address still hits.
- RST pulsed during FILL1 -> iREN=0 the next cycle; the earlier valid address 0x0 now misses. With ICACHE_STATS_EN: after scenario 1, hit_count=2, miss_count=1.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side handshake of the instruction cache, bundled as one interface.
// slave: the cache itself; master: the surrounding environment (datapath + memory).
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: combinational hits, 2-word block fill on a miss.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_responder #(
  parameter int unsigned SETS    = 16,
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               halt,
`ifdef ICACHE_STATS_EN
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count,
`endif
  icache_responder_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = 32 - IdxW - 3;

  typedef enum logic [1:0] {StIdle, StFill0, StFill1} state_e;

  state_e              state_q, state_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TagW-1:0]     tag_q  [SETS];
  logic [TagW-1:0]     tag_d  [SETS];
  logic [31:0]         data_q [SETS][2];
  logic [31:0]         data_d [SETS][2];
  logic [TagW-1:0]     ftag_q, ftag_d;
  logic [IdxW-1:0]     fidx_q, fidx_d;

  logic [TagW-1:0]     a_tag;
  logic [IdxW-1:0]     a_idx;
  logic                a_word;
  logic                lookup_hit;
  logic                unused_addr;

  assign a_tag       = bus.imemaddr[31:IdxW+3];
  assign a_idx       = bus.imemaddr[IdxW+2:3];
  assign a_word      = bus.imemaddr[2];
  assign unused_addr = ^bus.imemaddr[1:0];

  assign lookup_hit = bus.imemREN & valid_q[a_idx] & (tag_q[a_idx] == a_tag);

  // Outputs are forced low while reset is held so a stale frame cannot leak out.
  assign bus.ihit     = !RST & (state_q == StIdle) & lookup_hit;
  assign bus.imemload = bus.ihit ? data_q[a_idx][a_word] : '0;
  assign bus.iREN     = !RST & (state_q != StIdle);
  assign bus.iaddr    = bus.iREN ? {ftag_q, fidx_q, state_q == StFill1, 2'b00} : '0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    ftag_d  = ftag_q;
    fidx_d  = fidx_q;
`ifdef ICACHE_STATS_EN
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef ICACHE_STATS_EN
        if (lookup_hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
`endif
        if (bus.imemREN && !lookup_hit && !halt) begin
          ftag_d  = a_tag;
          fidx_d  = a_idx;
          state_d = StFill0;
`ifdef ICACHE_STATS_EN
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
        end
      end
      StFill0: begin
        if (!bus.iwait) begin
          data_d[fidx_q][0] = bus.iload;
          state_d           = StFill1;
        end
      end
      StFill1: begin
        // Frame becomes valid only once both words are in place.
        if (!bus.iwait) begin
          data_d[fidx_q][1] = bus.iload;
          tag_d[fidx_q]     = ftag_q;
          valid_d[fidx_q]   = 1'b1;
          state_d           = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
      ftag_q  <= '0;
      fidx_q  <= '0;
`ifdef ICACHE_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      ftag_q  <= ftag_d;
      fidx_q  <= fidx_d;
`ifdef ICACHE_STATS_EN
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: fills, conflicts, stalls, redirect, halt, reset mid-fill.
module tb_icache_responder;

  logic CLK = 1'b0;
  logic RST;
  logic halt;
  int   checks = 0;
  int   errors = 0;
  int   wait_cfg = 0;
  int   wait_cnt = 0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_responder_if bus ();

  icache_responder #(
    .SETS    (16),
    .PC_INIT (32'h0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .halt       (halt),
`ifdef ICACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Memory contents: two fixed words at 0x0/0x4, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign bus.iload = mem_word(bus.iaddr);
  assign bus.iwait = bus.iREN && (wait_cnt < wait_cfg);

  always @(posedge CLK) begin
    if (bus.iREN && bus.iwait) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Present a missing address now, follow both grants, end on the first hit cycle.
  task automatic run_miss(input logic [31:0] addr, input int stall);
    logic [31:0] blk;
    blk          = {addr[31:3], 3'b000};
    wait_cfg     = stall;
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    #1;
    check_eq("miss_ihit", bus.ihit, 1'b0);
    check_eq("miss_iren", bus.iREN, 1'b0);
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s <= stall; s++) begin
        tick();
        check_eq("fill_iren", bus.iREN, 1'b1);
        check_eq("fill_iaddr", bus.iaddr, blk + 32'(4 * w));
        check_eq("fill_ihit", bus.ihit, 1'b0);
        check_eq("fill_load", bus.imemload, 32'h0);
      end
    end
    tick();
    check_eq("post_fill_ihit", bus.ihit, 1'b1);
    check_eq("post_fill_load", bus.imemload, mem_word(addr));
    check_eq("post_fill_iren", bus.iREN, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  initial begin
    RST          = 1'b1;
    halt         = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    tick();
    tick();
    check_eq("rst_ihit", bus.ihit, 1'b0);
    check_eq("rst_load", bus.imemload, 32'h0);
    check_eq("rst_iren", bus.iREN, 1'b0);
    check_eq("rst_iaddr", bus.iaddr, 32'h0);

    // Cold miss at 0x0, then the second word of the block hits without a memory request.
    @(negedge CLK);
    RST = 1'b0;
    run_miss(32'h0, 0);
    tick();
    bus.imemaddr = 32'h4;
    #1;
    check_eq("word1_ihit", bus.ihit, 1'b1);
    check_eq("word1_load", bus.imemload, 32'h2222_2222);
    check_eq("word1_iren", bus.iREN, 1'b0);
    @(negedge CLK);
    bus.imemREN = 1'b0;
    #1;
    check_eq("ren0_ihit", bus.ihit, 1'b0);
`ifdef ICACHE_STATS_EN
    check_eq("hit_count", hit_count, 32'd2);
    check_eq("miss_count", miss_count, 32'd1);
`endif

    // Conflict on index 0: 0x80 evicts 0x0, which then misses again.
    @(negedge CLK);
    run_miss(32'h80, 0);
    @(negedge CLK);
    run_miss(32'h0, 0);

    // Memory stalls three cycles per grant.
    @(negedge CLK);
    run_miss(32'h8, 3);

    // Redirect during FILL0: block 0x10 still completes, then 0x40 fills.
    @(negedge CLK);
    wait_cfg     = 0;
    bus.imemaddr = 32'h10;
    tick();
    check_eq("redir_iaddr0", bus.iaddr, 32'h10);
    bus.imemaddr = 32'h40;
    tick();
    check_eq("redir_iaddr1", bus.iaddr, 32'h14);
    check_eq("redir_ihit", bus.ihit, 1'b0);
    tick();
    check_eq("redir_new_miss", bus.ihit, 1'b0);
    tick();
    check_eq("redir_fill_40", bus.iaddr, 32'h40);
    tick();
    check_eq("redir_fill_44", bus.iaddr, 32'h44);
    tick();
    check_eq("redir_hit_40", bus.imemload, mem_word(32'h40));
    bus.imemaddr = 32'h10;
    #1;
    check_eq("redir_hit_10", bus.ihit, 1'b1);
    check_eq("redir_load_10", bus.imemload, mem_word(32'h10));

    // halt blocks a new fill but still serves hits.
    @(negedge CLK);
    halt         = 1'b1;
    bus.imemaddr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("halt_iren", bus.iREN, 1'b0);
      check_eq("halt_ihit", bus.ihit, 1'b0);
    end
    bus.imemaddr = 32'h4;
    #1;
    check_eq("halt_hit", bus.ihit, 1'b1);
    check_eq("halt_load", bus.imemload, 32'h2222_2222);
    @(negedge CLK);
    halt = 1'b0;

    // Reset during FILL1 discards the fill and clears every frame.
    bus.imemaddr = 32'h308;
    tick();
    tick();
    check_eq("rstfill_iaddr", bus.iaddr, 32'h30C);
    RST = 1'b1;
    #1;
    check_eq("rstfill_iren_during", bus.iREN, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    run_miss(32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
